// File: rtl/rast_pkg.sv
// Shared types and constants for the rasterizer-to-frame-buffer pixel path.
package rast_pkg;

    localparam int H_RES_DEFAULT = 640;
    localparam int V_RES_DEFAULT = 480;
    localparam int X_W           = 10;
    localparam int Y_W           = 9;
    localparam int COLOR_W       = 3;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
    } pixel_t;

    localparam int PIXEL_W = $bits(pixel_t);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } rast_q_state_t;

endpackage

// File: rtl/rast_pixel_queue_if.sv
// Pixel handshakes: rasterizer -> queue (in_*) and queue -> frame buffer (rast_*).
interface rast_pixel_queue_if;
    import rast_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [COLOR_W-1:0] in_color;
    logic [X_W-1:0]     in_x;
    logic [Y_W-1:0]     in_y;
    logic               in_last;

    logic               rast_pixel_rdy;
    logic [COLOR_W-1:0] rast_color_input;
    logic [X_W-1:0]     rast_width;
    logic [Y_W-1:0]     rast_height;
    logic               read_rast_pixel_rdy;

    modport slave (
        input  in_valid, in_color, in_x, in_y, in_last, read_rast_pixel_rdy,
        output in_ready, rast_pixel_rdy, rast_color_input, rast_width, rast_height
    );

    modport master (
        output in_valid, in_color, in_x, in_y, in_last, read_rast_pixel_rdy,
        input  in_ready, rast_pixel_rdy, rast_color_input, rast_width, rast_height
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push on a full FIFO is legal only when a pop frees the slot in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    // NOTE: storage is deliberately not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rast_pixel_queue.sv
// Elastic pixel buffer with screen clipping and per-frame drain/done sequencing.
module rast_pixel_queue
    import rast_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int H_RES = H_RES_DEFAULT,
    parameter int V_RES = V_RES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    rast_pixel_queue_if.slave   bus,
    input  logic                next_frame_switch,
    output logic                rast_done,
    output logic [15:0]         drop_count
);
    localparam logic [X_W-1:0] H_LIM = X_W'(H_RES);
    localparam logic [Y_W-1:0] V_LIM = Y_W'(V_RES);

    rast_q_state_t state_q;
    rast_q_state_t state_d;
    pixel_t        in_pix;
    pixel_t        head_q;
    pixel_t        fifo_dout;
    logic          head_valid_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          accept;
    logic          in_range;
    logic          store;
    logic          consume;
    logic          bypass_ok;
    logic          to_head;

    assign in_pix    = '{color: bus.in_color, x: bus.in_x, y: bus.in_y};
    assign accept    = bus.in_valid & bus.in_ready;
    assign in_range  = (bus.in_x < H_LIM) && (bus.in_y < V_LIM);
    assign store     = accept & in_range;
    assign consume   = bus.read_rast_pixel_rdy & head_valid_q;
    // Bypassing the FIFO is only safe when nothing older is still waiting in it.
    assign bypass_ok = ~head_valid_q | (consume & fifo_empty);
    assign to_head   = store & bypass_ok;
    assign fifo_push = store & ~bypass_ok;
    assign fifo_pop  = consume & ~fifo_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_pix),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else if (to_head) begin
            head_q       <= in_pix;
            head_valid_q <= 1'b1;
        end else if (consume) begin
            if (!fifo_empty) head_q <= fifo_dout;
            head_valid_q <= ~fifo_empty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (state_q == DONE && next_frame_switch) begin
            drop_count <= '0;
        end else if (accept && !in_range && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // NOTE: default first so every path assigns state_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (accept && bus.in_last) state_d = DRAIN;
            // Exit on the consume that empties the queue so rast_done rises right after it.
            DRAIN: if (fifo_empty && (!head_valid_q || consume)) state_d = DONE;
            DONE:  if (next_frame_switch) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign bus.in_ready         = (state_q == RUN) & ~fifo_full;
    assign bus.rast_pixel_rdy   = head_valid_q;
    assign bus.rast_color_input = head_q.color;
    assign bus.rast_width       = head_q.x;
    assign bus.rast_height      = head_q.y;
    assign rast_done            = (state_q == DONE);

endmodule

// File: tb/tb_rast_pixel_queue.sv
// Directed bench for rast_pixel_queue with a scoreboard-driven output monitor.
module tb_rast_pixel_queue;
    import rast_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        next_frame_switch = 1'b0;
    logic        rast_done;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;
    pixel_t exp_q[$];

    rast_pixel_queue_if pq();

    rast_pixel_queue #(.DEPTH(16), .H_RES(640), .V_RES(480)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (pq),
        .next_frame_switch (next_frame_switch),
        .rast_done         (rast_done),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every consume seen by the frame buffer is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && pq.rast_pixel_rdy && pq.read_rast_pixel_rdy) begin
            pixel_t act;
            act = '{color: pq.rast_color_input, x: pq.rast_width, y: pq.rast_height};
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", 32'(act), 32'hFFFF_FFFF);
            end else begin
                pixel_t e;
                e = exp_q.pop_front();
                check("pixel_out", 32'(act), 32'(e));
            end
        end
    end

    task automatic send(input logic [9:0] x, input logic [8:0] y, input logic [2:0] c,
                        input logic last);
        bit ok = 0;
        pq.in_x = x; pq.in_y = y; pq.in_color = c; pq.in_last = last; pq.in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (pq.in_ready) ok = 1;
            @(posedge clk); #1;
        end
        pq.in_valid = 1'b0;
        pq.in_last  = 1'b0;
        check("send_accept", 32'(ok), 32'd1);
        if (ok && x < 10'd640 && y < 9'd480) exp_q.push_back('{color: c, x: x, y: y});
    endtask

    task automatic pulse_switch();
        next_frame_switch = 1'b1;
        @(posedge clk); #1;
        next_frame_switch = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (rast_done) seen = 1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        pq.in_valid = 0; pq.in_x = '0; pq.in_y = '0; pq.in_color = '0; pq.in_last = 0;
        pq.read_rast_pixel_rdy = 0;

        // Reset values
        #12;
        check("rst_in_ready", 32'(pq.in_ready), 32'd1);
        check("rst_rdy", 32'(pq.rast_pixel_rdy), 32'd0);
        check("rst_head", {10'd0, pq.rast_color_input, pq.rast_width, pq.rast_height}, 32'd0);
        check("rst_done", 32'(rast_done), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single pixel frame with immediate ack
        pq.read_rast_pixel_rdy = 1'b1;
        send(10'd5, 9'd7, 3'b101, 1'b1);
        @(negedge clk);
        check("latency_rdy", 32'(pq.rast_pixel_rdy), 32'd1);
        check("single_not_done", 32'(rast_done), 32'd0);
        @(negedge clk);
        check("single_done", 32'(rast_done), 32'd1);
        check("single_in_ready", 32'(pq.in_ready), 32'd0);
        @(posedge clk); #1;
        pulse_switch();
        @(negedge clk);
        check("switch_done", 32'(rast_done), 32'd0);
        check("switch_in_ready", 32'(pq.in_ready), 32'd1);
        check("switch_drop", 32'(drop_count), 32'd0);

        // Stall: 20 offered, 17 fit
        @(posedge clk); #1;
        pq.read_rast_pixel_rdy = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            pq.in_x = 10'(i * 3); pq.in_y = 9'(i * 2 + 1); pq.in_color = 3'(i);
            pq.in_valid = 1'b1;
            @(negedge clk);
            if (pq.in_ready) begin
                acc++;
                exp_q.push_back('{color: 3'(i), x: 10'(i * 3), y: 9'(i * 2 + 1)});
            end
            @(posedge clk); #1;
        end
        pq.in_valid = 1'b0;
        @(negedge clk);
        check("stall_accepted", 32'(acc), 32'd17);
        check("stall_in_ready", 32'(pq.in_ready), 32'd0);
        @(posedge clk); #1;
        pq.read_rast_pixel_rdy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("tput_rdy", 32'(pq.rast_pixel_rdy), 32'd1);
        end
        @(negedge clk);
        check("stall_drained", 32'(pq.rast_pixel_rdy), 32'd0);
        check("stall_sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;

        // Clipping at the screen boundaries
        send(10'd640, 9'd0, 3'b001, 1'b0);
        send(10'd0, 9'd480, 3'b010, 1'b0);
        send(10'd639, 9'd479, 3'b110, 1'b1);
        wait_done("clip_done");
        check("clip_drop", 32'(drop_count), 32'd2);
        check("clip_sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        pulse_switch();

        // Clipped last pixel on an empty queue
        send(10'd700, 9'd10, 3'b011, 1'b1);
        @(negedge clk);
        check("clip_last_drain", 32'(rast_done), 32'd0);
        @(negedge clk);
        check("clip_last_done", 32'(rast_done), 32'd1);
        check("clip_last_rdy", 32'(pq.rast_pixel_rdy), 32'd0);
        check("clip_last_drop", 32'(drop_count), 32'd1);
        @(posedge clk); #1;
        pulse_switch();

        // Switch ignored in DRAIN, then coincident with the drain exit
        pq.read_rast_pixel_rdy = 1'b0;
        send(10'd1, 9'd1, 3'b010, 1'b1);
        pulse_switch();
        @(negedge clk);
        check("drain_ignore_done", 32'(rast_done), 32'd0);
        check("drain_ignore_ready", 32'(pq.in_ready), 32'd0);
        check("drain_hold_rdy", 32'(pq.rast_pixel_rdy), 32'd1);
        @(posedge clk); #1;
        pq.read_rast_pixel_rdy = 1'b1;
        pulse_switch();
        @(negedge clk);
        check("coincide_done", 32'(rast_done), 32'd1);
        @(negedge clk);
        check("coincide_stays_done", 32'(rast_done), 32'd1);
        check("coincide_in_ready", 32'(pq.in_ready), 32'd0);
        @(posedge clk); #1;
        pulse_switch();

        // Asynchronous reset with pixels queued
        pq.read_rast_pixel_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(10'(100 + i), 9'(200 + i), 3'(i + 2), 1'b0);
        send(10'd800, 9'd0, 3'b111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rdy", 32'(pq.rast_pixel_rdy), 32'd0);
        check("arst_head", {10'd0, pq.rast_color_input, pq.rast_width, pq.rast_height}, 32'd0);
        check("arst_in_ready", 32'(pq.in_ready), 32'd1);
        check("arst_drop", 32'(drop_count), 32'd0);
        check("arst_done", 32'(rast_done), 32'd0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        pq.read_rast_pixel_rdy = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_queue_empty", 32'(pq.rast_pixel_rdy), 32'd0);

        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rast_pixel_queue.md
# rast_pixel_queue

Elastic buffer between the rasterizer core and the frame buffer's rasterizer port. It accepts pixels on a valid/ready handshake and discards pixels outside the 640x480 screen. It presents one pixel at a time on the frame buffer's `rast_pixel_rdy` / `read_rast_pixel_rdy` interface and raises `rast_done` once a frame has fully drained. The next frame is admitted only after the clipping unit's `next_frame_switch` pulse.

## Interface
- `DEPTH`, 16: FIFO entries behind the head register. Power of two, at least 2.
- `H_RES`, 640: visible width; pixels with x >= H_RES are dropped.
- `V_RES`, 480: visible height; pixels with y >= V_RES are dropped.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  rasterizer offers a pixel.
- `in_ready`  out  1  queue accepts the pixel this cycle.
- `in_color`  in  3  pixel colour.
- `in_x`  in  10  pixel column.
- `in_y`  in  9  pixel row.
- `in_last`  in  1  qualifies the final pixel of a frame.
- `next_frame_switch`  in  1  one-cycle pulse from the clipping unit.
- `rast_pixel_rdy`  out  1  head pixel valid toward the frame buffer.
- `rast_color_input`  out  3  head colour.
- `rast_width`  out  10  head x.
- `rast_height`  out  9  head y.
- `rast_done`  out  1  frame fully delivered.
- `read_rast_pixel_rdy`  in  1  frame buffer consumes the head this cycle.
- `drop_count`  out  16  saturating count of clipped pixels in the current frame.

## Operation
- Accept: a pixel is accepted when `in_valid & in_ready`. `in_ready = (state==RUN) & !fifo_full`.
- Clip: an accepted pixel with `in_x >= H_RES` or `in_y >= V_RES` is not stored and `drop_count` increments, saturating at 16'hFFFF.
- Store: an in-range pixel goes directly into the head register if the head is empty or is being consumed this cycle and the FIFO is empty. Otherwise it is pushed into the FIFO.
- Deliver: a consume is `read_rast_pixel_rdy & rast_pixel_rdy`.
  - On a consume, the head loads the FIFO top, or the bypass pixel, or becomes empty.
  - `read_rast_pixel_rdy` while the head is empty is ignored.
- State machine: RUN, DRAIN, DONE.
  - RUN -> DRAIN: an accepted pixel with `in_last=1`, whether it was stored or clipped.
  - DRAIN -> DONE: FIFO empty and head empty.
  - DONE -> RUN: `next_frame_switch=1`. This also clears `drop_count`.
  - `next_frame_switch` in RUN or DRAIN is ignored. If the DRAIN exit condition and a switch pulse coincide, the next state is DONE and the pulse is lost.
- `rast_done = (state==DONE)`. Outputs hold their last values while the head is empty; only `rast_pixel_rdy` is meaningful.
- Pixel order is preserved exactly. No pixel is duplicated or lost except by clipping.

## Timing
- Reset values:
  - state RUN
  - `in_ready` 1
  - `rast_pixel_rdy` 0
  - `rast_color_input` 0, `rast_width` 0, `rast_height` 0
  - `rast_done` 0
  - `drop_count` 0
- Reset mid-frame discards all queued pixels immediately (asynchronous).
- Latency: a pixel accepted at edge N into an empty queue shows `rast_pixel_rdy=1` in the cycle after edge N.
- Throughput: one pixel per cycle when `read_rast_pixel_rdy` is held high.
- Capacity: DEPTH+1 pixels. `in_ready` falls in the cycle after the push that fills the FIFO. A simultaneous push and pop on a full FIFO is allowed only when the pop frees space in the same cycle, so `in_ready` stays low that cycle.
- `rast_done` rises in the cycle after the consume that empties the queue. Clear `rast_done` on the edge that samples `next_frame_switch`.

## Structure
- Shared package `rast_pkg` holds:
  - `H_RES` and `V_RES` defaults
  - coordinate widths (10, 9) and colour width (3)
  - the pixel struct {color, x, y}
  - the `rast_q_state_t` enum {RUN, DRAIN, DONE}
- Sub-module `sync_fifo` (DEPTH, WIDTH=22) provides `full` and `empty` flags and pointers one bit wider than the address for wrap detection. Head register, bypass, clip logic and FSM live in the top.

## Test plan
- Single pixel (5,7,3'b101) with `in_last`, frame buffer acking at once -> `rast_pixel_rdy` high one cycle after accept with matching outputs, then `rast_done=1`, `in_ready=0`.
- Stall: push 20 pixels with `read_rast_pixel_rdy=0` -> 17 accepted, then `in_ready=0`. Release the ack -> all 17 delivered in order, one per cycle.
- Clip: pixels at (640,0), (0,480), (639,479) -> only (639,479) delivered, `drop_count=2`.
- A clipped last pixel (700,10,`in_last`) with the queue empty -> DONE two cycles later and no pixel delivered.
- Switch pulse during DRAIN is ignored. A switch in DONE gives RUN next cycle, `drop_count=0`, `in_ready=1`. A switch coincident with the drain exit leaves the block in DONE.
- Assert `rst_n=0` with 5 pixels queued -> outputs return to reset values asynchronously, and the queue is empty after release.
